wb_pack_engine: RTL and testbench

Parametrised result write-back engine between the MAC array and the result SRAM, generalising the fixed four-channel write-back stage. Each accepted batch of NCH unsigned MAC results is saturated to SLOT_W bits. It is then written raw, or reduced to a per-batch maximum or average. The engine packs slots into RAM_DW-bit words and issues one active-low SRAM write per completed word, with its own wrapping address generator.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_reduce.sv | 56 +++++
 rtl/wb_pack_engine.sv | 208 ++++++++++++++++++++
 tb/tb_wb_pack_engine.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg: mode codes, FSM encoding and helpers shared by the write-back engine
// Rev 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam logic [1:0] MODE_RAW = 2'd0;
    localparam logic [1:0] MODE_MAX = 2'd1;
    localparam logic [1:0] MODE_AVG = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2,
        FLUSH = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_reduce.sv
// ============================================================================
// wb_reduce: per-channel saturation plus max / average reduction of one batch
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_reduce
    import wb_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int RES_W  = 17,
    parameter int SLOT_W = 16
) (
    input  logic [NCH*RES_W-1:0]  res_in,
    input  logic [1:0]            mode,
    output logic [NCH*SLOT_W-1:0] slots,
    output logic [SLOT_W-1:0]     red_slot
);

    localparam int LOG_N = clog2(NCH);
    localparam int SUM_W = RES_W + LOG_N;
    localparam int EXT_W = RES_W + SLOT_W;

    // Widening to EXT_W lets the same compare work whether RES_W is above or below SLOT_W.
    function automatic logic [SLOT_W-1:0] saturate(input logic [RES_W-1:0] v);
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] lim;
        ext = EXT_W'(v);
        lim = EXT_W'({SLOT_W{1'b1}});
        return (ext > lim) ? lim[SLOT_W-1:0] : ext[SLOT_W-1:0];
    endfunction

    logic [SLOT_W-1:0] sat_c;
    logic [SLOT_W-1:0] max_slot;
    logic [SLOT_W-1:0] avg_slot;
    logic [SUM_W-1:0]  sum;

    always_comb begin
        slots    = '0;
        sat_c    = '0;
        max_slot = '0;
        sum      = '0;
        for (int c = 0; c < NCH; c++) begin
            sat_c = saturate(res_in[c*RES_W +: RES_W]);
            slots[c*SLOT_W +: SLOT_W] = sat_c;
            if (sat_c > max_slot) max_slot = sat_c;
            sum = sum + SUM_W'(res_in[c*RES_W +: RES_W]);
        end
        // Average uses raw results; saturation is applied only to the quotient.
        avg_slot = saturate(RES_W'(sum >> LOG_N));
        red_slot = (mode == MODE_AVG) ? avg_slot : max_slot;
    end

endmodule

`default_nettype wire

// File: rtl/wb_pack_engine.sv
// ============================================================================
// wb_pack_engine: packs saturated/reduced MAC results into SRAM words
// Rev 1.0
// ============================================================================
`default_nettype none

module wb_pack_engine
    import wb_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int RES_W     = 17,
    parameter int SLOT_W    = 16,
    parameter int RAM_DW    = 32,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int LAST_ADDR = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           mode,
    input  logic [NCH*RES_W-1:0] res_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 ram_cs_n,
    output logic                 ram_we_n,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [RAM_DW-1:0]    ram_wdata,
    output logic                 busy,
    output logic                 wrap,
    output logic                 done
);

    localparam int SLOTS  = RAM_DW / SLOT_W;
    localparam int NWORDS = NCH / SLOTS;
    localparam int FILL_W = (SLOTS > 1) ? clog2(SLOTS) : 1;
    localparam int REM_W  = clog2(NWORDS) + 1;
    localparam int BUF_W  = NCH * SLOT_W;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SLOTS - 1);
    localparam logic [REM_W-1:0]  REM_RAW   = REM_W'(NWORDS - 1);

    state_t            state, state_nxt;
    logic [1:0]        mode_q, mode_nxt;
    logic [RAM_DW-1:0] part, part_nxt, merged, issue_data;
    logic [FILL_W-1:0] fill, fill_nxt;
    logic [BUF_W-1:0]  wbuf, wbuf_nxt, sat_slots;
    logic [REM_W-1:0]  rem, rem_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [SLOT_W-1:0] red_slot;
    logic              flush_q, flush_nxt, issue, done_nxt, accept, raw_mode;

    wb_reduce #(
        .NCH    (NCH),
        .RES_W  (RES_W),
        .SLOT_W (SLOT_W)
    ) u_reduce (
        .res_in   (res_in),
        .mode     (mode_q),
        .slots    (sat_slots),
        .red_slot (red_slot)
    );

    assign accept   = in_ready & in_valid;
    assign raw_mode = (mode_q != MODE_MAX) && (mode_q != MODE_AVG);

    always_comb begin
        state_nxt  = state;
        mode_nxt   = mode_q;
        part_nxt   = part;
        fill_nxt   = fill;
        wbuf_nxt   = wbuf;
        rem_nxt    = rem;
        flush_nxt  = flush_q;
        addr_nxt   = addr;
        issue      = 1'b0;
        issue_data = '0;
        done_nxt   = 1'b0;
        merged     = part;
        merged[fill*SLOT_W +: SLOT_W] = red_slot;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    mode_nxt  = mode;
                    part_nxt  = '0;
                    fill_nxt  = '0;
                    rem_nxt   = '0;
                    flush_nxt = 1'b0;
                    addr_nxt  = BASE;
                end
            end
            RUN: begin
                if (accept) begin
                    if (raw_mode) begin
                        // First word goes out now; the rest are shifted out of wbuf in WRITE.
                        issue      = 1'b1;
                        issue_data = sat_slots[RAM_DW-1:0];
                        wbuf_nxt   = sat_slots >> RAM_DW;
                        rem_nxt    = REM_RAW;
                        state_nxt  = WRITE;
                    end else if (fill == FILL_LAST) begin
                        issue      = 1'b1;
                        issue_data = merged;
                        part_nxt   = '0;
                        fill_nxt   = '0;
                        rem_nxt    = '0;
                        state_nxt  = WRITE;
                    end else begin
                        part_nxt = merged;
                        fill_nxt = fill + 1'b1;
                    end
                end
                if (flush) begin
                    if (state_nxt == WRITE) begin
                        flush_nxt = 1'b1;
                    end else if (fill_nxt != '0) begin
                        issue      = 1'b1;
                        issue_data = part_nxt;
                        part_nxt   = '0;
                        fill_nxt   = '0;
                        state_nxt  = FLUSH;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                if (flush) flush_nxt = 1'b1;
                if (rem != '0) begin
                    issue      = 1'b1;
                    issue_data = wbuf[RAM_DW-1:0];
                    wbuf_nxt   = wbuf >> RAM_DW;
                    rem_nxt    = rem - 1'b1;
                end else if (flush_q || flush) begin
                    flush_nxt = 1'b0;
                    if (fill != '0) begin
                        issue      = 1'b1;
                        issue_data = part;
                        part_nxt   = '0;
                        fill_nxt   = '0;
                        state_nxt  = FLUSH;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = RUN;
                end
            end
            FLUSH: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) addr_nxt = (addr == LAST) ? BASE : addr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mode_q    <= MODE_RAW;
            part      <= '0;
            fill      <= '0;
            wbuf      <= '0;
            rem       <= '0;
            flush_q   <= 1'b0;
            addr      <= BASE;
            ram_cs_n  <= 1'b1;
            ram_we_n  <= 1'b1;
            ram_addr  <= BASE;
            ram_wdata <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            wrap      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            part      <= part_nxt;
            fill      <= fill_nxt;
            wbuf      <= wbuf_nxt;
            rem       <= rem_nxt;
            flush_q   <= flush_nxt;
            addr      <= addr_nxt;
            ram_cs_n  <= ~issue;
            ram_we_n  <= ~issue;
            if (issue) begin
                ram_addr  <= addr;
                ram_wdata <= issue_data;
            end
            in_ready  <= (state_nxt == RUN);
            busy      <= (state_nxt != IDLE);
            wrap      <= issue && (addr == LAST);
            done      <= done_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_pack_engine.sv
// ============================================================================
// tb_wb_pack_engine: directed + random batches against a slot-queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_pack_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [67:0] res_in = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;

    logic        in_ready, ram_cs_n, ram_we_n, busy, wrap, done;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        in_ready_w, ram_cs_n_w, ram_we_n_w, busy_w, wrap_w, done_w;
    logic [7:0]  ram_addr_w;
    logic [31:0] ram_wdata_w;

    always #5 clk = ~clk;

    wb_pack_engine dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .res_in(res_in),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .ram_cs_n(ram_cs_n), .ram_we_n(ram_we_n), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .busy(busy), .wrap(wrap), .done(done)
    );

    // Same stimulus, short address range to exercise wrap-around.
    wb_pack_engine #(.LAST_ADDR(1)) dut_w (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .res_in(res_in),
        .in_valid(in_valid), .in_ready(in_ready_w), .flush(flush),
        .ram_cs_n(ram_cs_n_w), .ram_we_n(ram_we_n_w), .ram_addr(ram_addr_w),
        .ram_wdata(ram_wdata_w), .busy(busy_w), .wrap(wrap_w), .done(done_w)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  a;
        logic        wr;
        logic [7:0]  aw;
        logic        wrw;
    } wr_t;

    wr_t         exp_q[$];
    int unsigned m_slots[$];
    int unsigned m_addr, m_addr_w;
    int          m_mode;
    int          total = 0;
    int          bad = 0;
    int unsigned b[4];
    int          nw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned sat16(input int unsigned v);
        return (v > 32'hFFFF) ? 32'hFFFF : v;
    endfunction

    task automatic push_word(input int unsigned d);
        wr_t e;
        e.data   = d;
        e.a      = 8'(m_addr);
        e.wr     = (m_addr == 255);
        m_addr   = (m_addr == 255) ? 0 : m_addr + 1;
        e.aw     = 8'(m_addr_w);
        e.wrw    = (m_addr_w == 1);
        m_addr_w = (m_addr_w == 1) ? 0 : m_addr_w + 1;
        exp_q.push_back(e);
    endtask

    task automatic model_batch(input int unsigned v[4], output int words);
        int unsigned s;
        words = 0;
        if (m_mode == 1 || m_mode == 2) begin
            if (m_mode == 1) begin
                s = 0;
                foreach (v[i]) if (sat16(v[i]) > s) s = sat16(v[i]);
            end else begin
                s = sat16((v[0] + v[1] + v[2] + v[3]) / 4);
            end
            m_slots.push_back(s);
            if (m_slots.size() == 2) begin
                push_word(m_slots[0] | (m_slots[1] << 16));
                m_slots.delete();
                words = 1;
            end
        end else begin
            push_word(sat16(v[0]) | (sat16(v[1]) << 16));
            push_word(sat16(v[2]) | (sat16(v[3]) << 16));
            words = 2;
        end
    endtask

    task automatic do_cycle(input bit want_done);
        wr_t e;
        @(posedge clk);
        #1;
        chk("we_follows_cs", ram_we_n, ram_cs_n);
        chk("cs_w_follows_cs", ram_cs_n_w, ram_cs_n);
        chk("done", done, want_done);
        if (ram_cs_n === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", ram_cs_n, 1'b1);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", ram_wdata, e.data);
                chk("addr", ram_addr, e.a);
                chk("wrap", wrap, e.wr);
                chk("wdata_w", ram_wdata_w, e.data);
                chk("addr_w", ram_addr_w, e.aw);
                chk("wrap_w", wrap_w, e.wrw);
            end
        end else begin
            chk("wrap_quiet", wrap, 1'b0);
            chk("wrap_w_quiet", wrap_w, 1'b0);
        end
    endtask

    task automatic do_start(input int m);
        start    = 1'b1;
        mode     = 2'(m);
        m_mode   = m;
        m_slots.delete();
        m_addr   = 0;
        m_addr_w = 0;
        do_cycle(1'b0);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        chk("ready_after_start", in_ready, 1'b1);
    endtask

    task automatic send_batch(input int unsigned v[4]);
        int n;
        int words;
        res_in   = {17'(v[3]), 17'(v[2]), 17'(v[1]), 17'(v[0])};
        in_valid = 1'b1;
        model_batch(v, words);
        do_cycle(1'b0);
        in_valid = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            n++;
            do_cycle(1'b0);
        end
        chk("ready_low_cycles", 64'(n), 64'(words));
        chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_flush();
        bit has;
        has = (m_slots.size() != 0);
        if (has) push_word(m_slots[0]);
        m_slots.delete();
        flush = 1'b1;
        do_cycle(!has);
        flush = 1'b0;
        if (has) do_cycle(1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_ready", in_ready, 1'b0);
        do_cycle(1'b0);
        chk("flush_writes_outstanding", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs_n", ram_cs_n, 1'b1);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_addr", ram_addr, 8'd0);
        chk("rst_wdata", ram_wdata, 32'd0);
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b1;
        do_cycle(1'b0);

        // RAW, saturation, then an empty flush
        do_start(0);
        b = '{1, 2, 3, 4};
        send_batch(b);
        b = '{32'h12345, 32'h0FFFF, 0, 32'h10000};
        send_batch(b);
        do_flush();

        // flush and start behaviour around IDLE/RUN
        flush = 1'b1;
        do_cycle(1'b0);
        flush = 1'b0;
        chk("flush_in_idle_busy", busy, 1'b0);

        // MAX across two batches; a stray start in RUN must not reload mode
        do_start(1);
        start = 1'b1;
        mode  = 2'd0;
        do_cycle(1'b0);
        start = 1'b0;
        chk("start_in_run_ready", in_ready, 1'b1);
        b = '{5, 9, 2, 7};
        send_batch(b);
        b = '{1, 1, 1, 3};
        send_batch(b);
        do_flush();

        // AVG partial word flushed
        do_start(2);
        b = '{4, 8, 12, 16};
        send_batch(b);
        do_flush();

        // Wrap: three RAW batches, short-range instance wraps every two writes
        do_start(0);
        for (int i = 0; i < 3; i++) begin
            foreach (b[c]) b[c] = $urandom_range(0, 32'h1FFFF);
            send_batch(b);
        end
        do_flush();

        // Random sessions in every mode; mode input wiggles during RUN
        for (int s = 0; s < 4; s++) begin
            do_start(int'($urandom_range(0, 3)));
            for (int i = 0; i < 7; i++) begin
                mode = 2'($urandom_range(0, 3));
                foreach (b[c]) b[c] = $urandom_range(0, 32'h1FFFF);
                send_batch(b);
                if ($urandom_range(0, 1) == 1) do_cycle(1'b0);
            end
            do_flush();
        end

        // Reset asserted on the first write cycle of a RAW batch
        do_start(0);
        b = '{11, 22, 33, 44};
        res_in   = {17'(b[3]), 17'(b[2]), 17'(b[1]), 17'(b[0])};
        in_valid = 1'b1;
        model_batch(b, nw);
        do_cycle(1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_cs_n", ram_cs_n, 1'b1);
        chk("midrst_we_n", ram_we_n, 1'b1);
        chk("midrst_addr", ram_addr, 8'd0);
        chk("midrst_wdata", ram_wdata, 32'd0);
        chk("midrst_ready", in_ready, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        exp_q.delete();
        repeat (3) do_cycle(1'b0);
        rst = 1'b1;
        do_start(0);
        b = '{7, 8, 9, 10};
        send_batch(b);
        do_flush();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
